// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce generator: FSM states, LFSR mask/seed
// and the single-step LFSR function.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step: the bit shifted out of q[0] selects the feedback taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Galois LFSR. It advances every cycle and can be reloaded with a seed; a zero
// seed would lock the register up, so zero is replaced by the reset seed.
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)    q <= SEED;
    else if (load) q <= (seed == 16'h0000) ? SEED : seed;
    else           q <= lfsr_step(q);
  end

endmodule

// File: rtl/bounce_gen.sv
// Mechanical contact bounce emulator: replays btn_clean edges as a random-length burst of
// LFSR noise followed by a settle pulse. Define BOUNCE_GEN_STATS_EN to add the event_cnt output.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int          BOUNCE_MIN = 4,
  parameter int          RANGE_LOG2 = 3,
  parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        btn_clean,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        btn_bouncy,
  output logic        bouncing,
  output logic        settle_done
`ifdef BOUNCE_GEN_STATS_EN
  ,
  output logic [15:0] event_cnt
`endif
);

  // RANGE_LOG2 may be 0, so the random field is taken by masking rather than slicing.
  localparam logic [15:0] RAND_MASK = 16'((1 << RANGE_LOG2) - 1);

  state_t      state, state_d;
  logic        level, level_d;
  logic        target, target_d;
  logic [8:0]  count, count_d;
  logic        bouncy_d;
  logic [15:0] lfsr_q;
  logic [8:0]  count_load;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load),
    .seed  (seed),
    .q     (lfsr_q)
  );

  assign count_load = 9'(BOUNCE_MIN) + 9'(lfsr_q & RAND_MASK);

  always_comb begin
    state_d  = state;
    level_d  = level;
    target_d = target;
    count_d  = count;
    if (!enable) begin
      state_d = IDLE;
      level_d = btn_clean;
      count_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_clean != level) begin
            target_d = btn_clean;
            count_d  = count_load;
            state_d  = BOUNCE;
          end
        end
        BOUNCE: begin
          // A new edge on the input restarts the burst with a fresh random length.
          if (btn_clean != target) begin
            target_d = btn_clean;
            count_d  = count_load;
          end else if (count <= 9'd1) begin
            count_d = '0;
            state_d = SETTLE;
          end else begin
            count_d = count - 9'd1;
          end
        end
        SETTLE: begin
          level_d = target;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    bouncy_d = level_d;
    case (state_d)
      BOUNCE:  bouncy_d = lfsr_q[0];
      SETTLE:  bouncy_d = target_d;
      default: bouncy_d = level_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      level       <= 1'b0;
      target      <= 1'b0;
      count       <= '0;
      btn_bouncy  <= 1'b0;
      bouncing    <= 1'b0;
      settle_done <= 1'b0;
    end else begin
      state       <= state_d;
      level       <= level_d;
      target      <= target_d;
      count       <= count_d;
      btn_bouncy  <= bouncy_d;
      bouncing    <= (state_d == BOUNCE);
      settle_done <= (state_d == SETTLE);
    end
  end

`ifdef BOUNCE_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)           event_cnt <= '0;
    else if (settle_done) event_cnt <= event_cnt + 16'd1;
  end
`endif

endmodule
